// File: rtl/vga_scandoubler_pkg.sv
// Shared definitions for the VGA scan doubler.
//   PIX_W         : pixel width, {r1,r0,g1,g0,b1,b0}
//   *_DEF         : default line length, output hsync width, buffer address width
//   pixel_t       : packed pixel with named colour fields, same bit order as the pins
package vga_scandoubler_pkg;

  localparam int unsigned PIX_W        = 6;
  localparam int unsigned LINE_LEN_DEF = 448;
  localparam int unsigned HS_LEN_DEF   = 54;
  localparam int unsigned AW_DEF       = 9;

  typedef struct packed {
    logic [1:0] r;
    logic [1:0] g;
    logic [1:0] b;
  } pixel_t;

endpackage

// File: rtl/scandbl_linebuf.sv
// Ping-pong line buffer: simple dual-port RAM, 2*2**AW entries of one pixel.
//   clk   : clock
//   we    : write enable
//   waddr : write address {bank, index}
//   wdata : write pixel
//   raddr : read address {bank, index}
//   rdata : read pixel, registered (valid one clock after raddr)
// No reset: contents persist across rst.
module scandbl_linebuf
  import vga_scandoubler_pkg::*;
#(
  parameter int unsigned AW = AW_DEF
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  pixel_t        wdata,
  input  logic [AW:0]   raddr,
  output pixel_t        rdata
);

  localparam int unsigned DEPTH = 2 * (2 ** AW);

  pixel_t mem [DEPTH];
  pixel_t rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/vga_scandoubler.sv
// TV-rate (15.6 kHz) to VGA-rate (31.2 kHz) scan doubler.
//   fclk          : 28 MHz clock
//   rst           : synchronous reset, active high
//   in_stb        : input pixel strobe, one fclk wide
//   in_pixel      : input pixel, valid with in_stb
//   in_line_start : one-fclk pulse at the start of each input line
//   in_vsync      : input vertical sync, active high
//   out_pixel     : doubled-rate pixel, black during hsync and until locked
//   out_hsync     : regenerated horizontal sync, active high
//   out_vsync     : vertical sync aligned to output line starts, active high
// Each input line is written into one buffer bank while the other bank
// (the previous line) is replayed twice at twice the pixel rate.
module vga_scandoubler
  import vga_scandoubler_pkg::*;
#(
  parameter int unsigned LINE_LEN = LINE_LEN_DEF,
  parameter int unsigned HS_LEN   = HS_LEN_DEF,
  parameter int unsigned AW       = AW_DEF
) (
  input  logic             fclk,
  input  logic             rst,
  input  logic             in_stb,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_line_start,
  input  logic             in_vsync,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_hsync,
  output logic             out_vsync
);

  localparam int unsigned   CW    = AW + 1;
  localparam logic [CW-1:0] WMAX  = CW'(LINE_LEN);
  localparam logic [CW-1:0] RLAST = CW'(LINE_LEN - 1);
  localparam logic [CW-1:0] HSW   = CW'(HS_LEN);

  logic          wbank_q,     wbank_d;
  logic [CW-1:0] wcnt_q,      wcnt_d;
  logic [CW-1:0] rcnt_q,      rcnt_d;
  logic          phase_q,     phase_d;
  logic          seen_q,      seen_d;
  logic          locked_q,    locked_d;
  logic          vs_samp_q,   vs_samp_d;
  pixel_t        out_pixel_q, out_pixel_d;
  logic          out_hsync_q, out_hsync_d;
  logic          out_vsync_q, out_vsync_d;

  logic          buf_we;
  logic [AW:0]   buf_waddr;
  logic [AW:0]   buf_raddr;
  pixel_t        buf_rdata;
  logic          in_sync;

  scandbl_linebuf #(
    .AW(AW)
  ) u_buf (
    .clk   (fclk),
    .we    (buf_we),
    .waddr (buf_waddr),
    .wdata (in_pixel),
    .raddr (buf_raddr),
    .rdata (buf_rdata)
  );

  always_comb begin
    wbank_d     = wbank_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    phase_d     = ~phase_q;
    seen_d      = seen_q;
    locked_d    = locked_q;
    vs_samp_d   = vs_samp_q;
    out_pixel_d = out_pixel_q;
    out_hsync_d = out_hsync_q;
    out_vsync_d = out_vsync_q;
    in_sync     = 1'b0;

    // Write side
    buf_we    = 1'b0;
    buf_waddr = {wbank_q, wcnt_q[AW-1:0]};
    if (in_line_start) begin
      wbank_d   = ~wbank_q;
      wcnt_d    = '0;
      vs_samp_d = in_vsync;
      seen_d    = 1'b1;
      // Second line start: the bank now being read holds a complete line
      if (seen_q) begin
        locked_d = 1'b1;
      end
      // Coincident strobe belongs to the new line: address 0 of the new bank
      if (in_stb) begin
        buf_we    = 1'b1;
        buf_waddr = {~wbank_q, {AW{1'b0}}};
        wcnt_d    = CW'(1);
      end
    end else if (in_stb && (wcnt_q < WMAX)) begin
      buf_we = 1'b1;
      wcnt_d = wcnt_q + 1'b1;
    end
    if (rst) begin
      buf_we = 1'b0;
    end

    // Read side: address goes out on phase 0, registered data lands on phase 1
    buf_raddr = {~wbank_q, rcnt_q[AW-1:0]};
    if (phase_q) begin
      in_sync     = (rcnt_q < HSW);
      out_hsync_d = locked_q & in_sync;
      if (locked_q && !in_sync) begin
        out_pixel_d = buf_rdata;
      end else begin
        out_pixel_d = '0;
      end
      if (rcnt_q == '0) begin
        out_vsync_d = locked_q & vs_samp_q;
      end
      rcnt_d = (rcnt_q == RLAST) ? '0 : rcnt_q + 1'b1;
    end
    if (in_line_start) begin
      rcnt_d  = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge fclk) begin
    if (rst) begin
      wbank_q     <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      phase_q     <= 1'b0;
      seen_q      <= 1'b0;
      locked_q    <= 1'b0;
      vs_samp_q   <= 1'b0;
      out_pixel_q <= '0;
      out_hsync_q <= 1'b0;
      out_vsync_q <= 1'b0;
    end else begin
      wbank_q     <= wbank_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      phase_q     <= phase_d;
      seen_q      <= seen_d;
      locked_q    <= locked_d;
      vs_samp_q   <= vs_samp_d;
      out_pixel_q <= out_pixel_d;
      out_hsync_q <= out_hsync_d;
      out_vsync_q <= out_vsync_d;
    end
  end

  assign out_pixel = out_pixel_q;
  assign out_hsync = out_hsync_q;
  assign out_vsync = out_vsync_q;

endmodule
